// File: rtl/lod_norm_pipe.sv
// Purpose : two-stage normalizer; stage 1 counts leading zeros, stage 2 shifts the MSB-first 1 to the top and subtracts the count from the exponent.
// Latency : 2 cycles from accepted input to out_valid_o; 1 beat/cycle throughput; holds up to 2 beats.
// Backpressure: valid/ready on both sides; in_ready_o follows out_ready_i combinationally when both stages are full.
//
// Ports:
//   clk_i, rst_ni                     clock (rising edge), async active-low reset
//   in_valid_i/in_ready_o             input handshake
//   in_data_i[N], in_exp_i[EW], in_tag_i[TW]   magnitude, signed exponent, sideband tag
//   out_valid_o/out_ready_i           output handshake
//   out_mant_o, out_exp_o, out_lzc_o, out_zero_o, out_tag_o, out_uflow_o   normalized result
//
// Optional build macro LOD_NORM_SAT_EN: clamps an underflowing exponent to -2^(EW-1) and
// raises out_uflow_o. Without it the exponent wraps modulo 2^EW and out_uflow_o stays 0.
module lod_norm_pipe #(
  parameter int N  = 64,
  parameter int EW = 12,
  parameter int TW = 4,
  parameter int S  = $clog2(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [N-1:0]  in_data_i,
  input  logic [EW-1:0] in_exp_i,
  input  logic [TW-1:0] in_tag_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [N-1:0]  out_mant_o,
  output logic [EW-1:0] out_exp_o,
  output logic [S-1:0]  out_lzc_o,
  output logic          out_zero_o,
  output logic [TW-1:0] out_tag_o,
  output logic          out_uflow_o
);

  logic v1, v2;
  logic adv1, adv2;

  logic [N-1:0]  s1_data;
  logic [EW-1:0] s1_exp;
  logic [TW-1:0] s1_tag;
  logic [S-1:0]  s1_lzc;
  logic          s1_zero;

  logic [S-1:0]  lzc_c;
  logic          zero_c;
  logic          found;

  logic [N-1:0]  mant_c;
  logic [EW-1:0] exp_c;
  logic          uflow_c;

  // A stage may load when it is empty or its contents move on this cycle.
  assign adv2        = ~v2 | out_ready_i;
  assign adv1        = ~v1 | adv2;
  assign in_ready_o  = adv1;
  assign out_valid_o = v2;

  // Leading-zero count: first 1 found scanning down from the MSB wins.
  // An all-zero input leaves the count at 0.
  assign zero_c = ~|in_data_i;
  always_comb begin
    lzc_c = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!found && in_data_i[i]) begin
        lzc_c = S'(N - 1 - i);
        found = 1'b1;
      end
    end
  end

  // Stage 2 arithmetic. The count is non-negative, so the only way out of
  // range is downward.
  assign mant_c = s1_data << s1_lzc;

`ifdef LOD_NORM_SAT_EN
  localparam logic [EW:0] EXP_MIN = {2'b11, {(EW-1){1'b0}}};
  logic [EW:0] exp_diff;
  always_comb begin
    exp_diff = {s1_exp[EW-1], s1_exp} - (EW+1)'(s1_lzc);
    uflow_c  = ($signed(exp_diff) < $signed(EXP_MIN));
    exp_c    = uflow_c ? EXP_MIN[EW-1:0] : exp_diff[EW-1:0];
  end
`else
  // Low EW bits of the wider difference are the same as an EW-bit subtract.
  always_comb begin
    exp_c   = s1_exp - EW'(s1_lzc);
    uflow_c = 1'b0;
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1      <= 1'b0;
      s1_data <= '0;
      s1_exp  <= '0;
      s1_tag  <= '0;
      s1_lzc  <= '0;
      s1_zero <= 1'b0;
    end else if (adv1) begin
      v1 <= in_valid_i;
      if (in_valid_i) begin
        s1_data <= in_data_i;
        s1_exp  <= in_exp_i;
        s1_tag  <= in_tag_i;
        s1_lzc  <= lzc_c;
        s1_zero <= zero_c;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v2          <= 1'b0;
      out_mant_o  <= '0;
      out_exp_o   <= '0;
      out_lzc_o   <= '0;
      out_zero_o  <= 1'b0;
      out_tag_o   <= '0;
      out_uflow_o <= 1'b0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        out_mant_o  <= mant_c;
        out_exp_o   <= exp_c;
        out_lzc_o   <= s1_lzc;
        out_zero_o  <= s1_zero;
        out_tag_o   <= s1_tag;
        out_uflow_o <= uflow_c;
      end
    end
  end

endmodule

// File: tb/tb_lod_norm_pipe.sv
module tb_lod_norm_pipe;

  typedef struct packed {
    logic [63:0] mant;
    logic [11:0] exp;
    logic [5:0]  lzc;
    logic        zero;
    logic [3:0]  tag;
    logic        uflow;
  } beat_t;

  logic clk, rst_n;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [63:0] in_data, out_mant;
  logic [11:0] in_exp, out_exp;
  logic [3:0]  in_tag, out_tag;
  logic [5:0]  out_lzc;
  logic        out_zero, out_uflow;
  beat_t       obs;

  // Secondary instances: N=40 (non power of two) and EW=8 (narrow exponent).
  logic        x_valid, x_oready, b_ready, c_ready, b_ovalid, c_ovalid;
  logic [3:0]  x_tag, b_otag, c_otag;
  logic [39:0] b_data, b_mant;
  logic [11:0] b_exp, b_oexp;
  logic [5:0]  b_lzc, c_lzc;
  logic        b_zero, c_zero, b_uflow, c_uflow;
  logic [63:0] c_data, c_mant;
  logic [7:0]  c_exp, c_oexp;

  int n_vec = 0;
  int n_err = 0;

  assign obs = {out_mant, out_exp, out_lzc, out_zero, out_tag, out_uflow};

  lod_norm_pipe #(.N(64), .EW(12), .TW(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_exp_i(in_exp), .in_tag_i(in_tag),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_mant_o(out_mant), .out_exp_o(out_exp), .out_lzc_o(out_lzc),
    .out_zero_o(out_zero), .out_tag_o(out_tag), .out_uflow_o(out_uflow)
  );

  lod_norm_pipe #(.N(40), .EW(12), .TW(4)) dut40 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(x_valid), .in_ready_o(b_ready),
    .in_data_i(b_data), .in_exp_i(b_exp), .in_tag_i(x_tag),
    .out_valid_o(b_ovalid), .out_ready_i(x_oready),
    .out_mant_o(b_mant), .out_exp_o(b_oexp), .out_lzc_o(b_lzc),
    .out_zero_o(b_zero), .out_tag_o(b_otag), .out_uflow_o(b_uflow)
  );

  lod_norm_pipe #(.N(64), .EW(8), .TW(4)) dut8 (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(x_valid), .in_ready_o(c_ready),
    .in_data_i(c_data), .in_exp_i(c_exp), .in_tag_i(x_tag),
    .out_valid_o(c_ovalid), .out_ready_i(x_oready),
    .out_mant_o(c_mant), .out_exp_o(c_oexp), .out_lzc_o(c_lzc),
    .out_zero_o(c_zero), .out_tag_o(c_otag), .out_uflow_o(c_uflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: count zeros from the top with a plain loop, shift, and do the
  // exponent arithmetic in integers before reducing to 12 bits.
  function automatic beat_t model(input logic [63:0] d, input logic [11:0] e, input logic [3:0] t);
    beat_t b;
    int lz;
    int ex;
    lz = 0;
    while (lz < 64 && d[63-lz] == 1'b0) lz++;
    b.zero = (lz == 64);
    if (b.zero) lz = 0;
    b.mant  = d << lz;
    ex      = int'($signed(e)) - lz;
    b.uflow = 1'b0;
`ifdef LOD_NORM_SAT_EN
    if (ex < -2048) begin
      ex      = -2048;
      b.uflow = 1'b1;
    end
`endif
    b.exp = 12'(ex);
    b.lzc = 6'(lz);
    b.tag = t;
    return b;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 0; out_ready = 0; in_data = '0; in_exp = '0; in_tag = '0;
    x_valid = 0; x_oready = 0; x_tag = '0;
    b_data = '0; b_exp = '0; c_data = '0; c_exp = '0;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || obs !== '0) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b outs=%h want valid=0 outs=0", out_valid, obs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
  endtask

  // Single beat through an empty pipe: not visible after 1 cycle, visible after 2.
  task automatic test_single(input string nm, input logic [63:0] d, input logic [11:0] e, input logic [3:0] t);
    beat_t x;
    x = model(d, e, t);
    @(negedge clk);
    in_valid = 1; in_data = d; in_exp = e; in_tag = t; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_latency1: got out_valid=%b want 0", nm, out_valid);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || obs !== x) begin
      n_err++;
      $display("FAIL %s: got valid=%b outs=%h want valid=1 outs=%h", nm, out_valid, obs, x);
    end
  endtask

  task automatic test_corners;
    // Values the bench expects from first principles for the three documented cases.
    test_single("lsb_one", 64'h1, 12'd0, 4'd1);
    n_vec++;
    if (out_mant !== 64'h8000_0000_0000_0000 || out_lzc !== 6'd63 || out_exp !== 12'hFC1 || out_zero !== 1'b0) begin
      n_err++;
      $display("FAIL lsb_one_const: got mant=%h lzc=%0d exp=%h zero=%b want 8000000000000000/63/fc1/0",
               out_mant, out_lzc, out_exp, out_zero);
    end
    test_single("msb_one", 64'h8000_0000_0000_0000, 12'd5, 4'd2);
    test_single("all_zero", 64'h0, 12'd7, 4'd3);
    n_vec++;
    if (out_mant !== 64'h0 || out_exp !== 12'd7 || out_zero !== 1'b1 || out_lzc !== 6'd0 || out_uflow !== 1'b0) begin
      n_err++;
      $display("FAIL all_zero_const: got mant=%h exp=%h zero=%b lzc=%0d uflow=%b want 0/7/1/0/0",
               out_mant, out_exp, out_zero, out_lzc, out_uflow);
    end
    test_single("underflow_edge", 64'h1, 12'h800, 4'd4);
  endtask

  task automatic test_back_to_back;
    beat_t x1, x2, x3;
    x1 = model(64'h0000_00F0_0000_0000, 12'd10, 4'd1);
    x2 = model(64'h0000_0000_0000_0301, 12'd20, 4'd2);
    x3 = model(64'h0400_0000_0000_0000, 12'hF00, 4'd3);
    @(negedge clk);
    out_ready = 0; in_valid = 1; in_data = 64'h0000_00F0_0000_0000; in_exp = 12'd10; in_tag = 4'd1;
    @(negedge clk);
    in_data = 64'h0000_0000_0000_0301; in_exp = 12'd20; in_tag = 4'd2;
    @(negedge clk);
    in_data = 64'h0400_0000_0000_0000; in_exp = 12'hF00; in_tag = 4'd3;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      n_vec++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== x1) begin
        n_err++;
        $display("FAIL b2b_stall%0d: got rdy=%b vld=%b outs=%h want 0/1/%h", k, in_ready, out_valid, obs, x1);
      end
    end
    @(negedge clk);
    out_ready = 1;
    #1;
    n_vec++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || obs !== x1) begin
      n_err++;
      $display("FAIL b2b_release: got rdy=%b vld=%b outs=%h want 1/1/%h", in_ready, out_valid, obs, x1);
    end
    @(negedge clk);
    in_valid = 0;
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || obs !== x2) begin
      n_err++;
      $display("FAIL b2b_beat2: got vld=%b outs=%h want 1/%h", out_valid, obs, x2);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b1 || obs !== x3) begin
      n_err++;
      $display("FAIL b2b_beat3: got vld=%b outs=%h want 1/%h", out_valid, obs, x3);
    end
    @(negedge clk);
    #1;
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_empty: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_npow2;
    @(negedge clk);
    x_valid = 1; x_oready = 1; x_tag = 4'd9; b_data = 40'h00_0000_0100; b_exp = 12'd0;
    @(negedge clk);
    x_valid = 0;
    @(negedge clk);
    #1;
    n_vec++;
    if (b_ovalid !== 1'b1 || b_ready !== 1'b1 || b_lzc !== 6'd31 || b_mant !== 40'h80_0000_0000 ||
        b_oexp !== 12'hFE1 || b_zero !== 1'b0 || b_otag !== 4'd9 || b_uflow !== 1'b0) begin
      n_err++;
      $display("FAIL n40: got vld=%b lzc=%0d mant=%h exp=%h zero=%b tag=%h want 1/31/8000000000/fe1/0/9",
               b_ovalid, b_lzc, b_mant, b_oexp, b_zero, b_otag);
    end
  endtask

  task automatic test_sat;
    logic [7:0] want_exp;
    logic       want_uf;
`ifdef LOD_NORM_SAT_EN
    want_exp = 8'h80; want_uf = 1'b1;
`else
    want_exp = 8'd93; want_uf = 1'b0;
`endif
    @(negedge clk);
    x_valid = 1; x_oready = 1; x_tag = 4'd5; c_data = 64'h1; c_exp = 8'h9C;
    @(negedge clk);
    x_valid = 0;
    @(negedge clk);
    #1;
    n_vec++;
    if (c_ovalid !== 1'b1 || c_ready !== 1'b1 || c_oexp !== want_exp || c_uflow !== want_uf ||
        c_lzc !== 6'd63 || c_mant !== 64'h8000_0000_0000_0000 || c_zero !== 1'b0 || c_otag !== 4'd5) begin
      n_err++;
      $display("FAIL ew8_uflow: got vld=%b exp=%h uflow=%b lzc=%0d mant=%h want 1/%h/%b/63/8000000000000000",
               c_ovalid, c_oexp, c_uflow, c_lzc, c_mant, want_exp, want_uf);
    end
  endtask

  task automatic test_random;
    beat_t q[$];
    beat_t held;
    logic  hold, acc, exp_rdy;
    hold = 0; acc = 0; in_valid = 0;
    for (int c = 0; c < 820; c++) begin
      @(negedge clk);
      if (c >= 800) begin
        in_valid = 0; out_ready = 1;
      end else begin
        out_ready = ($urandom_range(0, 3) != 0);
        if (!in_valid || acc) begin
          in_valid = ($urandom_range(0, 3) != 0);
          in_data  = {$urandom, $urandom} >> $urandom_range(0, 64);
          in_exp   = 12'($urandom);
          in_tag   = 4'($urandom);
        end
      end
      #1;
      if (hold) begin
        n_vec++;
        if (out_valid !== 1'b1 || obs !== held) begin
          n_err++;
          $display("FAIL rand_hold c=%0d: got vld=%b outs=%h want 1/%h", c, out_valid, obs, held);
        end
      end
      exp_rdy = !(q.size() == 2 && !out_ready);
      n_vec++;
      if (in_ready !== exp_rdy) begin
        n_err++;
        $display("FAIL rand_ready c=%0d: got %b want %b", c, in_ready, exp_rdy);
      end
      if (out_valid && out_ready) begin
        n_vec++;
        if (q.size() == 0 || obs !== q[0]) begin
          n_err++;
          $display("FAIL rand_out c=%0d: got %h want %h (queued %0d)", c, obs,
                   (q.size() > 0) ? q[0] : beat_t'('0), q.size());
        end
        if (q.size() > 0) void'(q.pop_front());
      end
      acc = in_valid && in_ready;
      if (acc) q.push_back(model(in_data, in_exp, in_tag));
      hold = out_valid && !out_ready;
      held = obs;
    end
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL rand_drain: got %0d beats left want 0", q.size());
    end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    out_ready = 0; in_valid = 1; in_data = 64'h0000_1234_0000_0000; in_exp = 12'd1; in_tag = 4'hA;
    @(negedge clk);
    in_data = 64'h55; in_tag = 4'hB;
    @(negedge clk);
    in_valid = 0;
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || obs !== '0) begin
      n_err++;
      $display("FAIL reset_mid: got vld=%b outs=%h want 0/0", out_valid, obs);
    end
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL reset_stale%0d: got vld=%b rdy=%b want 0/1", k, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_corners();
    test_back_to_back();
    test_npow2();
    test_sat();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lod_norm_pipe.md
Name: lod_norm_pipe

Overview:
- Two-stage pipelined normalizer that consumes a leading-zero count and left-shifts an unnormalized magnitude so its MSB is 1.
- Sits directly downstream of the leading-one detector in the PAU datapath: stage 1 computes the count (same semantics as the LOD: count of leading zeros from the MSB, plus a valid flag); stage 2 shifts and adjusts the exponent.
- Valid/ready handshake on both sides, so the PAU can stall it.

Parameters:
- N, 64, magnitude width; N >= 2; non-power-of-2 allowed (count computed as if zero-padded on the LSB side up to 2^S).
- EW, 12, signed exponent width.
- TW, 4, sideband tag width, passed through unchanged.
- S, $clog2(N), leading-zero count width (derived; not to be overridden).

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- in_valid_i  in  1  input beat valid
- in_ready_o  out  1  block can accept a beat this cycle
- in_data_i  in  N  unnormalized magnitude
- in_exp_i  in  EW  signed exponent associated with in_data_i
- in_tag_i  in  TW  sideband tag
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  consumer accepts output this cycle
- out_mant_o  out  N  normalized magnitude (MSB = 1 unless zero)
- out_exp_o  out  EW  in_exp_i - lzc, signed
- out_lzc_o  out  S  leading-zero count applied
- out_zero_o  out  1  input magnitude was all zeros
- out_tag_o  out  TW  tag of this beat
- out_uflow_o  out  1  exponent underflow flag (see Optional Feature)

Behaviour:
- Reset (rst_ni low, asynchronous): both stage valid bits cleared; out_valid_o=0; all data registers, out_mant_o, out_exp_o, out_lzc_o, out_zero_o, out_tag_o and out_uflow_o = 0. in_ready_o=1 from the first cycle after deassertion.
- Handshake:
  - Input transfer when in_valid_i & in_ready_o; output transfer when out_valid_o & out_ready_i.
  - out_* held stable while out_valid_o=1 and out_ready_i=0.
- Pipeline:
  - S1 register: data, exp, tag, lzc, zero. S2 register: outputs.
  - Stage advance: adv2 = ~v2 | out_ready_i; adv1 = ~v1 | adv2; in_ready_o = adv1.
  - Combinational paths: in_ready_o depends combinationally on out_ready_i. No other combinational input-to-output paths.
  - Latency 2 cycles from accepted input to out_valid_o with no stall; throughput 1 beat/cycle; capacity 2 beats.
  - Order is strictly preserved.
- Stage 1:
  - lzc = number of zeros above the most significant 1 of in_data_i.
  - zero = ~|in_data_i; lzc = 0 when zero = 1.
- Stage 2 arithmetic:
  - out_mant_o = data << lzc, truncated to N bits.
  - out_exp_o = exp - zero-extended lzc, computed in EW+1 bits and then reduced to EW bits.
  - out_lzc_o = lzc.
- Zero input: out_mant_o = 0, out_exp_o = in_exp_i unchanged, out_zero_o = 1, out_lzc_o = 0, out_uflow_o = 0.
- Simultaneous push and pop while full: both transfer in the same cycle, and occupancy is unchanged.
- Reset mid-operation: in-flight beats are discarded and never emerge.

Optional Feature:
- Macro: LOD_NORM_SAT_EN.
- Defined: if the EW+1-bit exponent difference is below -2^(EW-1), out_exp_o is clamped to -2^(EW-1) and out_uflow_o = 1 for that beat.
- Undefined: out_exp_o wraps modulo 2^EW, and out_uflow_o is tied to 0.

Test Plan:
- N=64, in_data=0x1, in_exp=0, out_ready=1 -> two cycles later: out_mant=0x8000_0000_0000_0000, out_lzc=63, out_exp=-63, out_zero=0.
- in_data=0x8000_0000_0000_0000, exp=5 -> out_mant unchanged, lzc=0, exp=5; in_data=0, exp=7 -> out_mant=0, exp=7, out_zero=1.
- Back-to-back beats with tags 1,2,3 and out_ready=0 -> in_ready_o drops after beats 1 and 2 are accepted, outputs hold beat 1 stable; raise out_ready -> tags emerge 1,2,3 in consecutive cycles.
- N=40, in_data=0x00_0000_0100, exp=0 -> lzc=31, out_mant=0x80_0000_0000, exp=-31.
- EW=8, in_exp=-100, in_data=0x1 (N=64) -> with LOD_NORM_SAT_EN: exp=-128, uflow=1; without it: exp=93, uflow=0.
- Two beats in flight, then rst_ni pulsed low asynchronously mid-cycle -> out_valid_o=0 immediately; after release, no stale beat appears and in_ready_o=1.
